// File: rtl/edge_light_pkg.sv
// -----------------------------------------------------------------------------
// edge_light_pkg
// Shared definitions for the edge-light scorer: the round-state encoding, the
// constants naming which field edge a light sits on, and a helper deciding
// whether the current button pair is an "outward only" press for that edge.
// -----------------------------------------------------------------------------
package edge_light_pkg;

    // Field edge encoding used by the SIDE parameter.
    localparam int SIDE_LEFT  = 0;  // player 1, outward button L
    localparam int SIDE_RIGHT = 1;  // player 2, outward button R

    // Seven-segment display widths.
    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    // Round state: PLAY while the ball is live, WIN for the single pulse
    // cycle, STOP until the next round or game reset.
    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        STOP = 2'd2
    } round_state_t;

    // True when only the outward button of this edge is pressed.
    function automatic logic outward_press(input int side, input logic l, input logic r);
        logic res;
        if (side == SIDE_RIGHT) begin
            res = r & ~l;
        end else begin
            res = l & ~r;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7.sv
// -----------------------------------------------------------------------------
// seg7
// Combinational decimal-digit to active-low seven-segment decoder.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
// Ports:
//   i_digit  [3:0] : binary digit, 0..9 are displayed
//   o_seg    [6:0] : active-low segment pattern, all segments off for 10..15
// -----------------------------------------------------------------------------
module seg7
    import edge_light_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg
);

    // Digit lookup; anything outside 0..9 blanks the display.
    always_comb begin
        o_seg = 7'b1111111;
        case (i_digit)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/edge_light_scorer.sv
// -----------------------------------------------------------------------------
// edge_light_scorer
// Edge light of a tug-of-war field plus the round FSM and match score of the
// player on that edge. The light moves in from the inner neighbour and out
// when the light is pushed away; pushing it off the field edge (outward button
// alone while lit) wins the round.
// Parameters:
//   SIDE       : 0 = left edge (outward button L), 1 = right edge (outward R)
//   MATCH_WINS : round wins that end the match, 1..9
//   CNT_W      : width of the score counter
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous round reset (light and FSM, score kept)
//   resetGame  : synchronous game reset (also clears the score)
//   L, R       : edge-detected button presses
//   NL, NR     : left / right neighbour lights
//   lightOn    : this light is lit
//   win        : single-cycle round-win pulse
//   matchWon   : score has reached MATCH_WINS
//   score      : current win count
//   hex        : active-low seven-segment image of score
// -----------------------------------------------------------------------------
module edge_light_scorer
    import edge_light_pkg::*;
#(
    parameter int SIDE       = 0,
    parameter int MATCH_WINS = 5,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resetGame,
    input  logic             L,
    input  logic             R,
    input  logic             NL,
    input  logic             NR,
    output logic             lightOn,
    output logic             win,
    output logic             matchWon,
    output logic [CNT_W-1:0] score,
    output logic [6:0]       hex
);

    // Parameter sanity checks at elaboration.
    generate
        if ((SIDE != SIDE_LEFT) && (SIDE != SIDE_RIGHT)) begin : g_bad_side
            $error("edge_light_scorer: SIDE must be 0 or 1");
        end
        if ((MATCH_WINS < 1) || (MATCH_WINS > 9)) begin : g_bad_wins
            $error("edge_light_scorer: MATCH_WINS must be within 1..9");
        end
        if (MATCH_WINS > ((1 << CNT_W) - 1)) begin : g_bad_cnt_w
            $error("edge_light_scorer: CNT_W too narrow for MATCH_WINS");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SCORE_MAX = CNT_W'(MATCH_WINS);
    localparam logic [CNT_W-1:0] SCORE_ONE = CNT_W'(1);

    round_state_t     r_state;
    logic             r_light;
    logic [CNT_W-1:0] r_score;

    round_state_t     w_state_next;
    logic             w_light_next;
    logic [CNT_W-1:0] w_score_next;
    logic             w_light_set;
    logic             w_outward;
    logic             w_win;
    logic             w_at_max;
    logic [DIGIT_W-1:0] w_digit;

    // Light enters from a lit neighbour when that player pushes it our way.
    assign w_light_set = (NR & L & ~R) | (NL & R & ~L);
    assign w_outward   = outward_press(SIDE, L, R);
    assign w_win       = (r_state == WIN);
    assign w_at_max    = (r_score == SCORE_MAX);

    // Round FSM next state and light next value; the light only moves in PLAY.
    always_comb begin
        w_state_next = r_state;
        w_light_next = r_light;
        case (r_state)
            PLAY: begin
                // Entry from a neighbour wins over a simultaneous push-away.
                if (w_light_set) begin
                    w_light_next = 1'b1;
                end else if (r_light && (L ^ R)) begin
                    w_light_next = 1'b0;
                end else begin
                    w_light_next = r_light;
                end
                if (r_light && w_outward) begin
                    w_state_next = WIN;
                end else begin
                    w_state_next = PLAY;
                end
            end
            WIN: begin
                w_state_next = STOP;
            end
            STOP: begin
                w_state_next = STOP;
            end
            default: begin
                // Unused encoding: park in STOP so no spurious win can follow.
                w_state_next = STOP;
            end
        endcase
    end

    // Saturating score increment on the win pulse.
    always_comb begin
        w_score_next = r_score;
        if (w_win && !w_at_max) begin
            w_score_next = r_score + SCORE_ONE;
        end else begin
            w_score_next = r_score;
        end
    end

    // Round FSM and light registers; a round reset during a won match locks
    // the round in STOP until the game reset.
    always_ff @(posedge clk) begin
        if (resetGame) begin
            r_state <= PLAY;
            r_light <= 1'b0;
        end else if (reset) begin
            r_state <= w_at_max ? STOP : PLAY;
            r_light <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_light <= w_light_next;
        end
    end

    // Score register; a round reset does not cancel a pending win.
    always_ff @(posedge clk) begin
        if (resetGame) begin
            r_score <= {CNT_W{1'b0}};
        end else begin
            r_score <= w_score_next;
        end
    end

    assign lightOn  = r_light;
    assign win      = w_win;
    assign score    = r_score;
    assign matchWon = w_at_max;

    // Score never exceeds 9, so the low digit bits carry the whole value.
    assign w_digit = DIGIT_W'(r_score);

    seg7 u_seg7 (
        .i_digit (w_digit),
        .o_seg   (hex)
    );

endmodule
